stack_calc_core: RTL and testbench
==================================

STACK_CALC_CORE -- requirements
Module: stack_calc_core

Interface
REQ-001 Parameter WIDTH, default 32, operand/stack word width in bits (>=8).
REQ-002 Parameter DEPTH, default 8, stack capacity in words (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 tok_valid  input  1  keypad token present.
REQ-006 tok  input  4  token code: 0x0-0x9 digit, 0xA add, 0xB sub, 0xC mul, 0xD enter, 0xE drop, 0xF clear-all.
REQ-007 tok_ready  output  1  core can accept a token; high exactly when FSM is IDLE.
REQ-008 display  output  WIDTH  entry if entry_active, else top of stack if depth>0, else 0.
REQ-009 depth  output  clog2(DEPTH+1)  number of words on stack.
REQ-010 busy  output  1  multiply in progress (inverse of tok_ready).
REQ-011 err_ovf, err_under, err_full  output  1 each  sticky error flags.

Function
REQ-012 Token accepted on a cycle with tok_valid && tok_ready; one token per acceptance; tokens offered while busy are not accepted and not lost (held by source).
REQ-013 Internal state: entry register (WIDTH), entry_active flag, DEPTH-word stack, FSM {IDLE, MUL}.
REQ-014 Digit d: entry_active=0 -> entry=d, entry_active=1; else entry=entry*10+d; if exact result > 2^WIDTH-1, digit ignored, entry unchanged, err_ovf set.
REQ-015 Enter, entry_active=1: push entry, clear entry and entry_active; if depth==DEPTH, no push, entry kept, err_full set.
REQ-016 Enter, entry_active=0: duplicate top; depth==0 -> err_under, depth==DEPTH -> err_full; stack unchanged on error.
REQ-017 Binary op, entry_active=1: a=top, b=entry; requires depth>=1; result replaces top; entry and entry_active cleared; depth unchanged.
REQ-018 Binary op, entry_active=0: a=second, b=top; requires depth>=2; both popped, result pushed; depth decrements by 1.
REQ-019 Operand shortage: err_under set; stack, entry and FSM unchanged.
REQ-020 Add/sub: result mod 2^WIDTH; carry out (add) or borrow (a<b, sub) sets err_ovf; wrapped result still written.
REQ-021 Add, sub, enter, drop, digit: effect visible on outputs the cycle after acceptance.
REQ-022 Mul: IDLE->MUL on acceptance; iterative shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, then ->IDLE writing low WIDTH bits of the product; nonzero high product bits set err_ovf.
REQ-023 Mul latency: tok_ready low for WIDTH cycles following acceptance edge; result on display and tok_ready high WIDTH+1 cycles after acceptance.
REQ-024 Operands of a multiply are captured at acceptance; stack and entry hold their pre-op values until the write cycle.
REQ-025 Drop: entry_active=1 -> entry=0, entry_active=0; else pop top; depth==0 -> err_under.
REQ-026 Clear-all: depth=0, entry=0, entry_active=0, all error flags cleared; next cycle.
REQ-027 Error flags stay set until clear-all or reset; errors never block later tokens.
REQ-028 Stack words beyond depth are don't-care; never observable at outputs.

Reset
REQ-029 When reset is high at a clock edge: FSM=IDLE, depth=0, entry=0, entry_active=0, all error flags 0, display=0, busy=0, tok_ready=1.
REQ-030 Reset during MUL aborts the multiply; no result is written.
REQ-031 Reset has priority over a token accepted in the same cycle; that token is discarded.

Verification (WIDTH=32, DEPTH=4)
REQ-032 Tokens 1,2,3,D -> depth=1, display=123, no errors.
REQ-033 1,2,D,3,4,A -> display=46, depth=1; then D,A -> display=92, depth=1.
REQ-034 7,D,6,C -> busy high 32 cycles, then display=42, depth=1, err_ovf=0; token held during busy accepted right after.
REQ-035 1,D,2,D,3,D,4,D,5,D -> depth=4, err_full=1, display=5 (entry kept); then F -> depth=0, flags 0.
REQ-036 After reset, A -> err_under=1, depth=0; 3,D,5,B -> display=0xFFFFFFFE, err_ovf=1.
REQ-037 Reset asserted mid-multiply (cycle 10 of MUL) -> next cycle depth=0, display=0, tok_ready=1.

Source files
------------

// File: rtl/stack_calc_core.sv
// stack_calc_core: RPN keypad calculator with entry register and DEPTH-word operand stack.
// Latency: digit/enter/drop/add/sub/clear visible the cycle after acceptance; mul result WIDTH+1 cycles after.
// Backpressure: tok_ready drops while a multiply iterates; offered tokens wait at the source.
module stack_calc_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tok_valid,
  input  logic [3:0]                 tok,
  output logic                       tok_ready,
  output logic [WIDTH-1:0]           display,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       err_ovf,
  output logic                       err_under,
  output logic                       err_full
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] TOK_ADD   = 4'hA;
  localparam logic [3:0] TOK_SUB   = 4'hB;
  localparam logic [3:0] TOK_MUL   = 4'hC;
  localparam logic [3:0] TOK_ENTER = 4'hD;
  localparam logic [3:0] TOK_DROP  = 4'hE;
  localparam logic [3:0] TOK_CLEAR = 4'hF;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state;
  logic [WIDTH-1:0]   entry_q;
  logic               entry_act_q;
  logic [WIDTH-1:0]   stack_mem [DEPTH];
  logic [DW-1:0]      depth_q;
  logic               ovf_q, under_q, full_q;

  // Multiplier: shifted multiplicand, remaining multiplier bits, running sum
  logic [2*WIDTH-1:0] mul_cand;
  logic [WIDTH-1:0]   mul_plier;
  logic [2*WIDTH-1:0] mul_acc;
  logic [CW-1:0]      mul_cnt;
  logic               mul_repl;

  logic [AW-1:0]      top_idx, sec_idx, push_idx, dst_idx;
  logic [WIDTH-1:0]   top_word, sec_word, opa, opb, diff;
  logic [WIDTH:0]     sum;
  logic               borrow, ops_ok, is_full, is_empty;
  logic [WIDTH+3:0]   dig_calc;
  logic               dig_ovf;
  logic [2*WIDTH-1:0] prod_next;

  assign top_idx  = AW'(depth_q - DW'(1));
  assign sec_idx  = AW'(depth_q - DW'(2));
  assign push_idx = AW'(depth_q);
  assign top_word = stack_mem[top_idx];
  assign sec_word = stack_mem[sec_idx];
  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);

  // With a live entry the entry is the right operand against top; otherwise second op top
  assign opa     = entry_act_q ? top_word : sec_word;
  assign opb     = entry_act_q ? entry_q  : top_word;
  assign ops_ok  = entry_act_q ? !is_empty : (depth_q >= DW'(2));
  assign dst_idx = entry_act_q ? top_idx : sec_idx;

  assign sum    = {1'b0, opa} + {1'b0, opb};
  assign diff   = opa - opb;
  assign borrow = (opa < opb);

  // entry*10 + d computed wide enough to hold the exact result
  assign dig_calc = ({4'b0, entry_q} << 3) + ({4'b0, entry_q} << 1) + {{WIDTH{1'b0}}, tok};
  assign dig_ovf  = |dig_calc[WIDTH+3:WIDTH];

  assign prod_next = mul_acc + (mul_plier[0] ? mul_cand : '0);

  assign tok_ready = (state == S_IDLE);
  assign busy      = (state == S_MUL);
  assign depth     = depth_q;
  assign err_ovf   = ovf_q;
  assign err_under = under_q;
  assign err_full  = full_q;

  // Display shows the entry being typed, else top of stack, else zero
  always_comb begin
    display = '0;
    if (entry_act_q)
      display = entry_q;
    else if (!is_empty)
      display = top_word;
  end

  // Token decode, stack update and iterative multiply sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      entry_q     <= '0;
      entry_act_q <= 1'b0;
      depth_q     <= '0;
      ovf_q       <= 1'b0;
      under_q     <= 1'b0;
      full_q      <= 1'b0;
      mul_cand    <= '0;
      mul_plier   <= '0;
      mul_acc     <= '0;
      mul_cnt     <= '0;
      mul_repl    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tok_valid) begin
            case (tok)
              TOK_ADD, TOK_SUB: begin
                if (!ops_ok) begin
                  under_q <= 1'b1;
                end else begin
                  stack_mem[dst_idx] <= (tok == TOK_ADD) ? sum[WIDTH-1:0] : diff;
                  if ((tok == TOK_ADD && sum[WIDTH]) || (tok == TOK_SUB && borrow))
                    ovf_q <= 1'b1;
                  if (entry_act_q) begin
                    entry_q     <= '0;
                    entry_act_q <= 1'b0;
                  end else begin
                    depth_q <= depth_q - DW'(1);
                  end
                end
              end
              TOK_MUL: begin
                if (!ops_ok) begin
                  under_q <= 1'b1;
                end else begin
                  state     <= S_MUL;
                  mul_cand  <= {{WIDTH{1'b0}}, opa};
                  mul_plier <= opb;
                  mul_acc   <= '0;
                  mul_cnt   <= '0;
                  mul_repl  <= entry_act_q;
                end
              end
              TOK_ENTER: begin
                if (entry_act_q) begin
                  if (is_full) begin
                    full_q <= 1'b1;
                  end else begin
                    stack_mem[push_idx] <= entry_q;
                    depth_q     <= depth_q + DW'(1);
                    entry_q     <= '0;
                    entry_act_q <= 1'b0;
                  end
                end else if (is_empty) begin
                  under_q <= 1'b1;
                end else if (is_full) begin
                  full_q <= 1'b1;
                end else begin
                  stack_mem[push_idx] <= top_word;
                  depth_q <= depth_q + DW'(1);
                end
              end
              TOK_DROP: begin
                if (entry_act_q) begin
                  entry_q     <= '0;
                  entry_act_q <= 1'b0;
                end else if (is_empty) begin
                  under_q <= 1'b1;
                end else begin
                  depth_q <= depth_q - DW'(1);
                end
              end
              TOK_CLEAR: begin
                depth_q     <= '0;
                entry_q     <= '0;
                entry_act_q <= 1'b0;
                ovf_q       <= 1'b0;
                under_q     <= 1'b0;
                full_q      <= 1'b0;
              end
              default: begin
                if (!entry_act_q) begin
                  entry_q     <= WIDTH'(tok);
                  entry_act_q <= 1'b1;
                end else if (dig_ovf) begin
                  ovf_q <= 1'b1;
                end else begin
                  entry_q <= dig_calc[WIDTH-1:0];
                end
              end
            endcase
          end
        end
        S_MUL: begin
          mul_acc   <= prod_next;
          mul_cand  <= mul_cand << 1;
          mul_plier <= mul_plier >> 1;
          mul_cnt   <= mul_cnt + CW'(1);
          if (mul_cnt == MUL_LAST) begin
            // Stack and entry are untouched during MUL, so dst_idx still names the operand slot
            state <= S_IDLE;
            stack_mem[dst_idx] <= prod_next[WIDTH-1:0];
            if (|prod_next[2*WIDTH-1:WIDTH])
              ovf_q <= 1'b1;
            if (mul_repl) begin
              entry_q     <= '0;
              entry_act_q <= 1'b0;
            end else begin
              depth_q <= depth_q - DW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_calc_core.sv
// tb_stack_calc_core: scoreboard bench for stack_calc_core (WIDTH=32, DEPTH=4).
// Driver applies tokens to a queue-based RPN model and pushes expected responses.
// Monitor pops one expectation per accepted token once tok_ready is high again.
module tb_stack_calc_core;

  localparam int W = 32;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        tok_valid;
  logic [3:0]  tok;
  logic        tok_ready;
  logic [W-1:0] display;
  logic [2:0]  depth;
  logic        busy;
  logic        err_ovf, err_under, err_full;

  stack_calc_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .tok_valid (tok_valid),
    .tok       (tok),
    .tok_ready (tok_ready),
    .display   (display),
    .depth     (depth),
    .busy      (busy),
    .err_ovf   (err_ovf),
    .err_under (err_under),
    .err_full  (err_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] disp;
    logic [2:0]  dep;
    logic        ovf;
    logic        under;
    logic        full;
    int          cyc;   // expected busy cycles, -1 = not checked
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stack as a queue (back = top)
  logic [31:0] m_stk[$];
  logic [31:0] m_entry;
  logic        m_act, m_ovf, m_under, m_full;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endfunction

  function automatic void m_reset();
    m_stk.delete();
    m_entry = '0;
    m_act = 1'b0; m_ovf = 1'b0; m_under = 1'b0; m_full = 1'b0;
  endfunction

  // Applies one token; returns number of busy cycles it causes
  function automatic int m_apply(input logic [3:0] t);
    logic [63:0] a, b, r, v;
    int n;
    int cyc;
    n = m_stk.size();
    cyc = 0;
    a = '0; b = '0; r = '0; v = '0;
    case (t)
      4'hA, 4'hB, 4'hC: begin
        if ((m_act && n >= 1) || (!m_act && n >= 2)) begin
          if (m_act) begin a = 64'(m_stk[n-1]); b = 64'(m_entry); end
          else begin a = 64'(m_stk[n-2]); b = 64'(m_stk[n-1]); end
          if (t == 4'hA) r = a + b;
          else if (t == 4'hB) r = a - b;   // a<b wraps to a value above 2^32-1
          else begin r = a * b; cyc = W; end
          if (r > 64'h0000_0000_FFFF_FFFF) m_ovf = 1'b1;
          if (m_act) begin
            m_stk[n-1] = r[31:0];
            m_entry = '0; m_act = 1'b0;
          end else begin
            void'(m_stk.pop_back());
            m_stk[n-2] = r[31:0];
          end
        end else begin
          m_under = 1'b1;
        end
      end
      4'hD: begin
        if (m_act) begin
          if (n == D) m_full = 1'b1;
          else begin m_stk.push_back(m_entry); m_entry = '0; m_act = 1'b0; end
        end else if (n == 0) m_under = 1'b1;
        else if (n == D) m_full = 1'b1;
        else m_stk.push_back(m_stk[n-1]);
      end
      4'hE: begin
        if (m_act) begin m_entry = '0; m_act = 1'b0; end
        else if (n == 0) m_under = 1'b1;
        else void'(m_stk.pop_back());
      end
      4'hF: m_reset();
      default: begin
        if (!m_act) begin m_entry = 32'(t); m_act = 1'b1; end
        else begin
          v = 64'(m_entry) * 64'd10 + 64'(t);
          if (v > 64'h0000_0000_FFFF_FFFF) m_ovf = 1'b1;
          else m_entry = v[31:0];
        end
      end
    endcase
    return cyc;
  endfunction

  function automatic exp_t m_expect(input int cyc);
    exp_t e;
    e.disp  = m_act ? m_entry : ((m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 32'd0);
    e.dep   = 3'(m_stk.size());
    e.ovf   = m_ovf;
    e.under = m_under;
    e.full  = m_full;
    e.cyc   = cyc;
    return e;
  endfunction

  // Monitor: a token seen valid&ready at a negedge is accepted at the next posedge
  initial begin : monitor
    exp_t e;
    bit   pend;
    int   bc;
    pend = 1'b0;
    bc = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (tok_ready || bc >= 100) begin
          pend = 1'b0;
          if (!tok_ready) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout: tok_ready still low after %0d cycles", bc);
          end
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL resp_unexpected: response with empty scoreboard");
          end else begin
            e = sb_q.pop_front();
            check("resp_display", 64'(display), 64'(e.disp));
            check("resp_depth",   64'(depth),   64'(e.dep));
            check("resp_err_ovf", 64'(err_ovf), 64'(e.ovf));
            check("resp_err_under", 64'(err_under), 64'(e.under));
            check("resp_err_full",  64'(err_full),  64'(e.full));
            if (e.cyc >= 0) check("resp_busy_cycles", 64'(bc), 64'(e.cyc));
          end
        end else begin
          bc++;
        end
      end
      if (!pend && !reset && tok_valid && tok_ready) begin
        pend = 1'b1;
        bc = 0;
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge
  task automatic send(input logic [3:0] t);
    int guard;
    guard = 0;
    tok = t;
    tok_valid = 1'b1;
    @(negedge clk);
    while (!tok_ready && guard < 100) begin guard++; @(negedge clk); end
    if (!tok_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_accept: token 0x%0h not accepted, tok_ready=%0b", t, tok_ready);
    end else begin
      sb_q.push_back(m_expect(m_apply(t)));
    end
    @(posedge clk); #1;
  endtask

  task automatic send_seq(input logic [3:0] ts[$]);
    foreach (ts[i]) send(ts[i]);
  endtask

  task automatic drain();
    int g;
    g = 0;
    tok_valid = 1'b0;
    @(negedge clk);
    while ((sb_q.size() != 0 || !tok_ready) && g < 200) begin g++; @(negedge clk); end
    if (g >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: pending=%0d tok_ready=%0b", sb_q.size(), tok_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tok_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [3:0] seq[$];
    int r;
    reset = 1'b1;
    tok_valid = 1'b0;
    tok = 4'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_display",   64'(display),   64'd0);
    check("rst_depth",     64'(depth),     64'd0);
    check("rst_tok_ready", 64'(tok_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_flags", 64'({err_ovf, err_under, err_full}), 64'd0);

    // 1,2,3,Enter
    seq = '{4'h1, 4'h2, 4'h3, 4'hD};
    send_seq(seq); drain();
    check("d123_display", 64'(display), 64'd123);
    check("d123_depth",   64'(depth),   64'd1);
    check("d123_flags", 64'({err_ovf, err_under, err_full}), 64'd0);

    // 12 Enter 34 Add, then Enter Add
    do_reset();
    seq = '{4'h1, 4'h2, 4'hD, 4'h3, 4'h4, 4'hA};
    send_seq(seq); drain();
    check("add46_display", 64'(display), 64'd46);
    check("add46_depth",   64'(depth),   64'd1);
    seq = '{4'hD, 4'hA};
    send_seq(seq); drain();
    check("dup_add92_display", 64'(display), 64'd92);
    check("dup_add92_depth",   64'(depth),   64'd1);

    // Reset wins over a token offered in the same cycle
    reset = 1'b1; tok_valid = 1'b1; tok = 4'h5;
    @(posedge clk); #1;
    reset = 1'b0; tok_valid = 1'b0;
    m_reset();
    @(negedge clk);
    check("rst_prio_display", 64'(display), 64'd0);
    check("rst_prio_depth",   64'(depth),   64'd0);
    @(posedge clk); #1;

    // 7 Enter 6 Mul, with a digit held while busy
    seq = '{4'h7, 4'hD, 4'h6, 4'hC};
    send_seq(seq); drain();
    check("mul42_display", 64'(display), 64'd42);
    check("mul42_depth",   64'(depth),   64'd1);
    check("mul42_ovf",     64'(err_ovf), 64'd0);
    seq = '{4'h2, 4'hC, 4'h1};
    send_seq(seq); drain();
    check("held_tok_display", 64'(display), 64'd1);
    check("held_tok_depth",   64'(depth),   64'd1);

    // Fill to capacity, then overflow the stack, then clear-all
    do_reset();
    seq = '{4'h1, 4'hD, 4'h2, 4'hD, 4'h3, 4'hD, 4'h4, 4'hD, 4'h5, 4'hD};
    send_seq(seq); drain();
    check("full_depth",   64'(depth),    64'd4);
    check("full_flag",    64'(err_full), 64'd1);
    check("full_display", 64'(display),  64'd5);
    send(4'hF); drain();
    check("clr_depth", 64'(depth), 64'd0);
    check("clr_flags", 64'({err_ovf, err_under, err_full}), 64'd0);

    // Underflow on empty, then 3 - 5 wraps
    do_reset();
    send(4'hA); drain();
    check("under_flag",  64'(err_under), 64'd1);
    check("under_depth", 64'(depth),     64'd0);
    seq = '{4'h3, 4'hD, 4'h5, 4'hB};
    send_seq(seq); drain();
    check("sub_wrap_display", 64'(display), 64'hFFFF_FFFE);
    check("sub_wrap_ovf",     64'(err_ovf), 64'd1);

    // Reset in cycle 10 of a multiply aborts it
    do_reset();
    seq = '{4'h2, 4'hD, 4'h3};
    send_seq(seq); drain();
    tok = 4'hC; tok_valid = 1'b1;
    @(negedge clk);
    check("abort_ready_pre", 64'(tok_ready), 64'd1);
    m_reset();
    sb_q.push_back(m_expect(-1));
    @(posedge clk); #1 tok_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_display",   64'(display),   64'd0);
    check("abort_depth",     64'(depth),     64'd0);
    check("abort_tok_ready", 64'(tok_ready), 64'd1);
    drain();

    // Randomized token stream
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      send(4'($urandom_range(0, 9)));
      else if (r < 60) send(4'hD);
      else if (r < 72) send(4'hA);
      else if (r < 80) send(4'hB);
      else if (r < 88) send(4'hC);
      else if (r < 97) send(4'hE);
      else             send(4'hF);
      if ($urandom_range(0, 3) == 0) begin
        tok_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
